pack_narrow_wide: RTL
=====================

Name: pack_narrow_wide

Overview:
Parametrised narrow-to-wide word packer. It is the successor of the fixed 8b-to-32b converter in the byte-lane datapath.
- Accepts IN_W-bit beats on a valid/ready handshake and packs RATIO beats into one OUT_W-bit word.
- Presents the packed word on a valid/ready output handshake with a byte-lane enable mask.
- Adds downstream backpressure, selectable lane order and a flush that emits partial words.

Parameters:
IN_W, 8, width of one input beat (bits).
RATIO, 4, beats per output word; legal range 2..16.
MSB_FIRST, 1, 1: first beat lands in the most-significant lane; 0: first beat lands in lane 0 (LSBs).
(derived localparams) OUT_W = IN_W*RATIO; CNT_W = clog2(RATIO).

Ports:
clk_4f  in  1  single clock; all logic on rising edge.
reset  in  1  asynchronous, active-high reset.
data_in  in  IN_W  input beat.
valid_in  in  1  data_in valid.
ready_out  out  1  block can accept a beat this cycle.
flush_in  in  1  request to emit the current partial word.
data_out  out  OUT_W  packed word.
lane_en_out  out  RATIO  bit i=1: slice [i*IN_W +: IN_W] of data_out holds a real beat.
valid_out  out  1  data_out/lane_en_out valid.
ready_in  in  1  downstream accepts the word this cycle.

Behaviour:
- Reset (async assert, sync release): data_out=0, lane_en_out=0, valid_out=0, accumulator=0, lane_cnt=0, mask=0. Reset mid-word discards the partial word; nothing is emitted.
- State: accumulator (OUT_W), accumulated mask (RATIO), lane_cnt (0..RATIO-1), one-entry output register (data_out/lane_en_out/valid_out).
- slot_free = !valid_out || ready_in (combinational).
- ready_out = slot_free || (lane_cnt != RATIO-1). This is combinational from registers and ready_in; it never depends on valid_in.
- Beat accepted when valid_in && ready_out. Beat k (k = lane_cnt) is written to lane L:
  - L = RATIO-1-k if MSB_FIRST=1.
  - L = k if MSB_FIRST=0.
  - Accepting sets mask bit L.
- Word completion (accept with lane_cnt==RATIO-1):
  - Next cycle: data_out = accumulator with that beat merged; lane_en_out = all ones; valid_out=1.
  - Accumulator, mask and lane_cnt are cleared.
  - Latency: last beat accepted at edge N, word visible after edge N.
- Output handshake:
  - valid_out stays high and data_out stays stable until ready_in=1.
  - A transfer and a new word load on the same edge give back-to-back words with no bubble.
- Flush:
  - flush_in is honoured only on cycles with slot_free=1. Otherwise it is ignored and the source holds it.
  - Honoured with mask != 0, or with a beat accepted the same cycle: emit {accumulator + this beat}. lane_en_out = accumulated mask; unfilled lanes read 0. Clear state.
  - Honoured with a beat that completes a word: behaves exactly as a normal completion. One word only; no extra empty word.
  - Honoured with mask==0 and no beat: no-op; valid_out is not raised.
- Throughput: one beat per cycle sustained when ready_in=1; one word per RATIO cycles.
- No overflow is possible: beats are never dropped. The source must hold valid_in/data_in while ready_out=0.

Decomposition:
- Package pack_pkg holds:
  - clog2 function.
  - lane_index(k, RATIO, MSB_FIRST) function.
  - Width localparam helpers.
- Sub-module pack_out_stage holds the output register and the slot_free/valid/ready logic. It is parametrised by OUT_W and RATIO.
- Top module holds the accumulator, lane counter and flush logic.

Test Plan:
- Defaults, ready_in=1, beats AA,BB,CC,DD on 4 consecutive cycles -> one cycle after DD: data_out=AABBCCDD, lane_en_out=1111, valid_out=1 for 1 cycle. Same with MSB_FIRST=0 -> DDCCBBAA.
- Continuous stream of 12 beats 01..0C, ready_in=1 -> words 01020304, 05060708, 090A0B0C on cycles 5, 9, 13; ready_out stays 1 throughout.
- Backpressure:
  - Setup: word 1 pending with ready_in=0; offer 4 more beats.
  - Expected while ready_in=0: 3 beats accepted, ready_out=0 at the 4th; data_out holds word 1 stable.
  - Then raise ready_in: word 1 transferred, 4th beat accepted on the same edge, word 2 valid next cycle.
- Partial flush: beats 11,22 then flush_in=1 -> data_out=11220000, lane_en_out=1100. Flush with no beats pending -> valid_out stays 0.
- Flush on the same cycle as the 4th beat 44 (after 11,22,33) -> single word 11223344, lane_en_out=1111; no second word.
- Reset mid-word:
  - Stimulus: beats 11,22; assert reset asynchronously between edges; release; send A1,A2,A3,A4.
  - Expected: outputs go 0 immediately on assert; the only word emitted is A1A2A3A4 with lane_en_out=1111.

Source files
------------

// File: rtl/pack_pkg.sv
// Shared helpers for the narrow-to-wide packer: width math and lane placement.
// Latency: n/a (compile-time functions and constants only).
// Backpressure: n/a.
package pack_pkg;

  localparam int DEF_IN_W  = 8;
  localparam int DEF_RATIO = 4;

  // Ceiling log2, at least 1 so a counter always has a bit to live in.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Width of a packed word built from 'ratio' beats of 'in_w' bits.
  function automatic int out_width(input int in_w, input int ratio);
    return in_w * ratio;
  endfunction

  // Lane that beat number k of a word occupies.
  function automatic int lane_index(input int k, input int ratio, input int msb_first);
    return (msb_first != 0) ? (ratio - 1 - k) : k;
  endfunction

endpackage

// File: rtl/pack_out_stage.sv
// One-entry output register holding a packed word and its lane mask.
// Latency: a word loaded at edge N is visible after edge N.
// Backpressure: holds word stable while ready_in=0; slot_free allows load+drain on one edge.
module pack_out_stage #(
  parameter int OUT_W = 32,
  parameter int RATIO = 4
) (
  input  logic             clk_4f,
  input  logic             reset,
  input  logic             load,
  input  logic [OUT_W-1:0] load_dat,
  input  logic [RATIO-1:0] load_mask,
  input  logic             ready_in,
  output logic [OUT_W-1:0] data_out,
  output logic [RATIO-1:0] lane_en_out,
  output logic             valid_out,
  output logic             slot_free
);

  // The slot can take a new word when it is empty or is being drained this edge.
  assign slot_free = !valid_out || ready_in;

  // Load a new word (caller only loads when slot_free), else drop valid once drained.
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      data_out    <= '0;
      lane_en_out <= '0;
      valid_out   <= 1'b0;
    end else if (load) begin
      data_out    <= load_dat;
      lane_en_out <= load_mask;
      valid_out   <= 1'b1;
    end else if (ready_in) begin
      valid_out   <= 1'b0;
    end
  end

endmodule

// File: rtl/pack_narrow_wide.sv
// Packs RATIO narrow IN_W beats into one OUT_W word with a lane-enable mask; flush emits partials.
// Latency: word visible one edge after its last (or flushing) beat is accepted.
// Backpressure: ready_out drops only when the final lane is due and the output slot is busy.
module pack_narrow_wide
  import pack_pkg::*;
#(
  parameter int IN_W      = DEF_IN_W,
  parameter int RATIO     = DEF_RATIO,
  parameter int MSB_FIRST = 1,
  localparam int OUT_W    = out_width(IN_W, RATIO),
  localparam int CNT_W    = clog2(RATIO)
) (
  input  logic             clk_4f,
  input  logic             reset,
  input  logic [IN_W-1:0]  data_in,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic             flush_in,
  output logic [OUT_W-1:0] data_out,
  output logic [RATIO-1:0] lane_en_out,
  output logic             valid_out,
  input  logic             ready_in
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

  logic [OUT_W-1:0] acc;
  logic [RATIO-1:0] mask;
  logic [CNT_W-1:0] lane_cnt;
  logic [CNT_W-1:0] lane;
  logic [OUT_W-1:0] merged_dat;
  logic [RATIO-1:0] merged_mask;
  logic             slot_free;
  logic             accept;
  logic             last_beat;
  logic             flush_go;
  logic             load;

  // Only the beat that completes a word needs the output slot; earlier beats
  // go into the accumulator regardless of downstream state.
  assign ready_out = slot_free || (lane_cnt != LAST_CNT);
  assign accept    = valid_in && ready_out;
  assign last_beat = accept && (lane_cnt == LAST_CNT);
  // A flush with nothing accumulated and no beat arriving emits nothing.
  assign flush_go  = flush_in && slot_free && ((mask != '0) || accept);
  assign load      = last_beat || flush_go;

  // Lane the current beat lands in, set by the lane-order parameter.
  always_comb begin
    lane = CNT_W'(lane_index(int'(lane_cnt), RATIO, MSB_FIRST));
  end

  // Accumulator and mask with this cycle's beat merged in; this is what gets emitted.
  always_comb begin
    merged_dat  = acc;
    merged_mask = mask;
    if (accept) begin
      merged_dat[int'(lane)*IN_W +: IN_W] = data_in;
      merged_mask[lane]                   = 1'b1;
    end
  end

  // Accumulate beats; clear everything whenever a word (full or partial) is handed off.
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      acc      <= '0;
      mask     <= '0;
      lane_cnt <= '0;
    end else if (load) begin
      acc      <= '0;
      mask     <= '0;
      lane_cnt <= '0;
    end else if (accept) begin
      acc      <= merged_dat;
      mask     <= merged_mask;
      lane_cnt <= lane_cnt + CNT_W'(1);
    end
  end

  pack_out_stage #(
    .OUT_W (OUT_W),
    .RATIO (RATIO)
  ) u_out_stage (
    .clk_4f      (clk_4f),
    .reset       (reset),
    .load        (load),
    .load_dat    (merged_dat),
    .load_mask   (merged_mask),
    .ready_in    (ready_in),
    .data_out    (data_out),
    .lane_en_out (lane_en_out),
    .valid_out   (valid_out),
    .slot_free   (slot_free)
  );

endmodule
